// File: rtl/uart8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart8_pkg
// Brief    : Shared types and constants for the oversampled 8-bit UART receiver.
// Revision : 1.0
// ============================================================================
package uart8_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

  function automatic int calc_tick_div(input int clock_rate, input int baud_rate,
                                       input int oversample);
    return clock_rate / (baud_rate * oversample);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart8_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart8_baud_tick
// Brief    : Oversample tick divider with synchronous restart; 1-cycle tick.
// Revision : 1.0
// ============================================================================
module uart8_baud_tick #(
  parameter int TICK_DIV = 78
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int             CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/uart8_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart8_receiver
// Brief    : 8N1 UART receiver, 16x oversampling, 2-flop sync, 3-sample vote.
//            Define UART_PARITY_EN to add an even-parity bit after data bit 7.
// Revision : 1.0
// ============================================================================
module uart8_receiver
  import uart8_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxEn,
  input  logic       rx,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] out
);

  localparam int TICK_DIV = calc_tick_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int SMP_W    = $clog2(OVERSAMPLE);
  localparam int IDX_W    = $clog2(DATA_BITS);

  // A sample index k is taken on the tick that advances the counter from k-1 to k,
  // so the three votes sit at OVERSAMPLE/2-1, /2, /2+1 ticks into the bit.
  localparam logic [SMP_W-1:0] SMP_A    = SMP_W'(OVERSAMPLE/2 - 2);
  localparam logic [SMP_W-1:0] SMP_B    = SMP_W'(OVERSAMPLE/2 - 1);
  localparam logic [SMP_W-1:0] SMP_VOTE = SMP_W'(OVERSAMPLE/2);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs, rxs_prev_q, rxs_prev_d;
  rx_state_e              state_q, state_d;
  logic [SMP_W-1:0]       sample_cnt_q, sample_cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [7:0]             out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   vs_a_q, vs_a_d, vs_b_q, vs_b_d;
  logic                   tick, restart, vote, vote_now, bit_end, frame_ok;
`ifdef UART_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  uart8_baud_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign vote     = (vs_a_q & vs_b_q) | (vs_a_q & rxs) | (vs_b_q & rxs);
  assign vote_now = tick && (sample_cnt_q == SMP_VOTE);
  assign bit_end  = tick && (sample_cnt_q == SMP_LAST);

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], rx};
    rxs_prev_d   = rxs;
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    out_d        = out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    vs_a_d       = vs_a_q;
    vs_b_d       = vs_b_q;
    restart      = 1'b0;
    frame_ok     = 1'b0;
`ifdef UART_PARITY_EN
    parity_d     = parity_q;
`endif

    if (state_q != IDLE && tick) begin
      sample_cnt_d = (sample_cnt_q == SMP_LAST) ? '0 : sample_cnt_q + SMP_W'(1);
      if (sample_cnt_q == SMP_A) vs_a_d = rxs;
      if (sample_cnt_q == SMP_B) vs_b_d = rxs;
    end

    if (state_q != IDLE && !rxEn) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sample_cnt_d = '0;
          if (rxEn && rxs_prev_q && !rxs) begin
            state_d = START;
            busy_d  = 1'b1;
            restart = 1'b1;
          end
        end
        START: begin
          if (vote_now && vote) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (bit_end) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          if (vote_now) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (bit_end) begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            if (bit_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (vote_now) parity_d = vote;
          if (bit_end)  state_d  = STOP;
        end
`endif
        STOP: begin
          // Leave at the mid-bit vote so a back-to-back start edge is still seen.
          if (vote_now) begin
`ifdef UART_PARITY_EN
            frame_ok = vote && (parity_q == ^shift_q);
`else
            frame_ok = vote;
`endif
            state_d = IDLE;
            busy_d  = 1'b0;
            if (frame_ok) begin
              out_d  = shift_q;
              done_d = 1'b1;
            end else begin
              err_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '1;
      rxs_prev_q   <= 1'b1;
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      out_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      vs_a_q       <= 1'b1;
      vs_b_q       <= 1'b1;
`ifdef UART_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      rxs_prev_q   <= rxs_prev_d;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      out_q        <= out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      vs_a_q       <= vs_a_d;
      vs_b_q       <= vs_b_d;
`ifdef UART_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign rxBusy = busy_q;
  assign rxDone = done_q;
  assign rxErr  = err_q;
  assign out    = out_q;

endmodule
`default_nettype wire

// File: tb/tb_uart8_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart8_receiver
// Brief    : Randomized self-checking bench for uart8_receiver with a
//            frame-level reference model (UART_PARITY_EN aware).
// Revision : 1.0
// ============================================================================
module tb_uart8_receiver;

  localparam int CLOCK_RATE = 768000;
  localparam int BAUD_RATE  = 9600;
  localparam int OVERSAMPLE = 16;
  localparam int TICK       = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int BIT        = TICK * OVERSAMPLE;
`ifdef UART_PARITY_EN
  localparam int EXTRA      = BIT;
`else
  localparam int EXTRA      = 0;
`endif
  localparam int EXP_LAT    = 9*BIT + 8*TICK + 3 + EXTRA;
  localparam int TOL        = 2*TICK + 5;

  logic       clk = 1'b0;
  logic       rst, rxEn, rx;
  logic       rxBusy, rxDone, rxErr;
  logic [7:0] out;

  uart8_receiver #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rxEn  (rxEn),
    .rx    (rx),
    .rxBusy(rxBusy),
    .rxDone(rxDone),
    .rxErr (rxErr),
    .out   (out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       done;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Pulse monitor: every rxDone/rxErr must match the next frame the model expects.
  initial begin : monitor
    exp_t e;
    int   lat;
    forever begin
      @(posedge clk);
      #1;
      if (rxDone || rxErr) begin
        check("pulse_outside_rst", {31'd0, rst}, 0);
        check("done_err_exclusive", {31'd0, rxDone & rxErr}, 0);
        check("busy_clear_at_pulse", {31'd0, rxBusy}, 0);
        check("pulse_expected", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pulse_is_done", {31'd0, rxDone}, {31'd0, e.done});
          if (e.done) last_good = e.data;
          check("out_value", {24'd0, out}, {24'd0, last_good});
          lat = cyc - e.start;
          check("latency", (lat >= EXP_LAT - TOL && lat <= EXP_LAT + TOL) ? EXP_LAT : lat,
                EXP_LAT);
        end
      end
    end
  end

  // abort_mode: 0 none, 1 drop rxEn in data bit 4, 2 pulse rst in data bit 4.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_ok,
                            input int gap_bits, input int abort_mode);
    logic bits[$];
    logic killed;
    exp_t e;
    bits = {};
    killed = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_PARITY_EN
    bits.push_back((^d) ^ ~par_ok);
    e.done = stop_bit && par_ok;
`else
    e.done = stop_bit;
`endif
    @(negedge clk);
    e.data  = d;
    e.start = cyc;
    if (abort_mode == 0) exp_q.push_back(e);
    bits.push_back(stop_bit);
    for (int b = 0; b < bits.size(); b++) begin
      rx = killed ? 1'b1 : bits[b];
      for (int c = 0; c < BIT; c++) begin
        @(negedge clk);
        if (abort_mode != 0 && !killed && b == 5 && c == BIT/2) begin
          check("busy_before_abort", {31'd0, rxBusy}, 1);
          if (abort_mode == 1) begin
            rxEn = 1'b0;
          end else begin
            rst = 1'b1;
            rx  = 1'b1;
          end
          @(negedge clk);
          rst = 1'b0;
          check("busy_after_abort", {31'd0, rxBusy}, 0);
          if (abort_mode == 2) last_good = 8'h00;
          check("out_after_abort", {24'd0, out}, {24'd0, last_good});
          killed = (abort_mode == 2);
        end
      end
    end
    rx = 1'b1;
    repeat (gap_bits * BIT) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin : main
    int         t_rise, t_fall, gap;
    logic       rose, busy_seen, sb, po;
    logic [7:0] d;

    rst = 1'b1; rxEn = 1'b0; rx = 1'b1; last_good = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_out",  {24'd0, out}, 0);
    check("reset_busy", {31'd0, rxBusy}, 0);
    check("reset_done", {31'd0, rxDone}, 0);
    check("reset_err",  {31'd0, rxErr}, 0);
    rst = 1'b0; rxEn = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(8'h45, 1'b1, 1'b1, 1, 0);
    send_frame(8'hA5, 1'b1, 1'b1, 0, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 1, 0);
    send_frame(8'h12, 1'b1, 1'b1, 1, 0);
`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1, 0);
    send_frame(8'h07, 1'b1, 1'b1, 1, 0);
`endif

    // Short low glitch on an idle line: a false start that clears itself.
    rose = 1'b0; t_rise = 0;
    rx = 1'b0;
    for (int c = 0; c < BIT/4; c++) begin
      @(negedge clk);
      if (rxBusy && !rose) begin
        rose = 1'b1;
        t_rise = cyc;
      end
    end
    rx = 1'b1;
    for (int i = 0; i < 2*BIT; i++) begin
      if (!rxBusy) break;
      @(negedge clk);
    end
    t_fall = cyc;
    check("glitch_busy_rose", {31'd0, rose}, 1);
    check("glitch_busy_clear", {31'd0, rxBusy}, 0);
    check("glitch_busy_len",
          (t_fall - t_rise >= BIT/2 - TOL && t_fall - t_rise <= BIT/2 + TOL) ? BIT/2
                                                                             : t_fall - t_rise,
          BIT/2);
    repeat (BIT) @(negedge clk);

    send_frame(8'h5A, 1'b1, 1'b1, 2, 1);
    rxEn = 1'b1;
    repeat (BIT) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b1, 2, 2);
    send_frame(8'h81, 1'b1, 1'b1, 1, 0);

    // Line already low when the receiver is enabled: no start without an edge.
    rxEn = 1'b0; rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rxEn = 1'b1;
    busy_seen = 1'b0;
    repeat (2*BIT) begin
      @(negedge clk);
      if (rxBusy) busy_seen = 1'b1;
    end
    check("line_low_no_start", {31'd0, busy_seen}, 0);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);

    for (int n = 0; n < 20; n++) begin
      d   = 8'($urandom);
      sb  = ($urandom_range(0, 3) != 0);
      po  = ($urandom_range(0, 3) != 0);
      gap = sb ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, sb, po, gap, 0);
    end

    repeat (2*BIT) @(negedge clk);
    check("no_pending_frames", exp_q.size(), 0);
    check("final_out", {24'd0, out}, {24'd0, last_good});
    check("final_busy", {31'd0, rxBusy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
